// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
//
// Streams a program image from an upstream valid/ready source into an
// asynchronous SRAM-style memory, then verifies a trailing checksum.
//
// Image order: LEN, BASE, LEN program words, SUM.
// Every program word is written with a fixed strobe sequence:
//   WR_SETUP (1 cycle) -> WR_PULSE (WE_PULSE cycles, WE low) -> WR_HOLD (1 cycle).
//
// Parameters
//   WE_PULSE   cycles WE is held low per write (1..15)
//   MAX_WORDS  largest accepted LEN
//
// Ports
//   clock         single rising-edge clock
//   reset_n       asynchronous active-low reset
//   in_valid      upstream word present
//   in_data       upstream word
//   in_ready      loader accepts a word this cycle
//   Address       memory word address (holds its last value between writes)
//   Data          memory data bus, driven only while CS is low
//   CS, WE, OE    active-low memory strobes (OE never asserted)
//   boot_done     image loaded and checksum matched (registered)
//   boot_error    image rejected on length or checksum (registered)
//   words_loaded  program words written since reset
// ---------------------------------------------------------------------------
module boot_loader #(
    parameter int unsigned WE_PULSE  = 2,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic [31:0] Address,
    inout  logic [31:0] Data,
    output logic        CS,
    output logic        WE,
    output logic        OE,
    output logic        boot_done,
    output logic        boot_error,
    output logic [31:0] words_loaded
);

    typedef enum logic [3:0] {
        StGetLen,
        StGetBase,
        StGetWord,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StGetSum,
        StDone,
        StError
    } state_e;

    localparam logic [3:0]  PulseLast = 4'(WE_PULSE - 1);
    localparam logic [31:0] MaxLen    = 32'(MAX_WORDS);

    state_e      r_state;
    state_e      w_state_next;

    // Low during reset and for the cycle after release, so in_ready only
    // rises on the first clock edge after reset_n deasserts.
    logic        r_live;

    logic [31:0] r_len;
    logic [31:0] r_base;
    logic [31:0] r_word;
    logic [31:0] r_sum;
    logic [31:0] r_count;
    logic [31:0] r_addr;
    logic [3:0]  r_pulse;
    logic        r_done;
    logic        r_err;

    logic        w_xfer;
    logic        w_get_state;
    logic        w_wr_state;
    logic [31:0] w_count_inc;

    // ------------------------------------------------------------------
    // Next-state and strobe decode
    // ------------------------------------------------------------------
    always_comb begin
        w_get_state  = 1'b0;
        w_wr_state   = 1'b0;
        w_state_next = r_state;
        w_count_inc  = r_count + 32'd1;

        unique case (r_state)
            StGetLen, StGetBase, StGetWord, StGetSum: w_get_state = 1'b1;
            StWrSetup, StWrPulse, StWrHold:           w_wr_state  = 1'b1;
            default: ;
        endcase

        w_xfer = in_valid && r_live && w_get_state;

        case (r_state)
            StGetLen: begin
                if (w_xfer) begin
                    w_state_next = (in_data > MaxLen) ? StError : StGetBase;
                end
            end
            StGetBase: begin
                if (w_xfer) begin
                    w_state_next = (r_len == 32'd0) ? StGetSum : StGetWord;
                end
            end
            StGetWord: begin
                if (w_xfer) begin
                    w_state_next = StWrSetup;
                end
            end
            StWrSetup: begin
                w_state_next = StWrPulse;
            end
            StWrPulse: begin
                if (r_pulse == PulseLast) begin
                    w_state_next = StWrHold;
                end
            end
            StWrHold: begin
                w_state_next = (w_count_inc == r_len) ? StGetSum : StGetWord;
            end
            StGetSum: begin
                if (w_xfer) begin
                    w_state_next = (in_data == r_sum) ? StDone : StError;
                end
            end
            StDone:  w_state_next = StDone;
            StError: w_state_next = StError;
            default: w_state_next = StError;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StGetLen;
            r_live  <= 1'b0;
            r_len   <= 32'd0;
            r_base  <= 32'd0;
            r_word  <= 32'd0;
            r_sum   <= 32'd0;
            r_count <= 32'd0;
            r_addr  <= 32'd0;
            r_pulse <= 4'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
            // Flags follow the next state so they assert on the same edge
            // that enters DONE/ERROR and are mutually exclusive by design.
            r_done  <= (w_state_next == StDone);
            r_err   <= (w_state_next == StError);

            if (w_xfer) begin
                unique case (r_state)
                    StGetLen:  r_len  <= in_data;
                    StGetBase: r_base <= in_data;
                    StGetWord: begin
                        r_word <= in_data;
                        r_sum  <= r_sum + in_data;
                        // Address is set on acceptance so it is already valid
                        // throughout WR_SETUP; wraps naturally at 2^32.
                        r_addr <= r_base + r_count;
                    end
                    default: ;
                endcase
            end

            if (r_state == StWrSetup) begin
                r_pulse <= 4'd0;
            end else if (r_state == StWrPulse) begin
                r_pulse <= r_pulse + 4'd1;
            end

            if (r_state == StWrHold) begin
                r_count <= w_count_inc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes decode straight from the state register, so the
    // asynchronous reset of r_state releases CS/WE without a clock edge.
    // ------------------------------------------------------------------
    assign in_ready     = r_live && w_get_state;
    assign CS           = !w_wr_state;
    assign WE           = (r_state != StWrPulse);
    assign OE           = 1'b1;
    assign Address      = r_addr;
    assign Data         = w_wr_state ? r_word : 32'bz;
    assign boot_done    = r_done;
    assign boot_error   = r_err;
    assign words_loaded = r_count;

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

    localparam int unsigned WE_PULSE  = 2;
    localparam int unsigned MAX_WORDS = 1024;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic [31:0] Address;
    wire  [31:0] mem_data;
    logic        CS;
    logic        WE;
    logic        OE;
    logic        boot_done;
    logic        boot_error;
    logic [31:0] words_loaded;

    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    int          we_cnt = 0;
    int          last_start = -1;
    int          cs_cycles = 0;
    bit          period_en = 1'b0;
    logic        prev_we = 1'b1;
    logic [63:0] cur_exp = 64'd0;
    logic [63:0] exp_q[$];
    logic [31:0] img[$];

    boot_loader #(
        .WE_PULSE  (WE_PULSE),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .Address      (Address),
        .Data         (mem_data),
        .CS           (CS),
        .WE           (WE),
        .OE           (OE),
        .boot_done    (boot_done),
        .boot_error   (boot_error),
        .words_loaded (words_loaded)
    );

    initial forever #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: pops the scoreboard at each WE falling edge and checks
    // address/data stability and the WE pulse width.
    always @(negedge clock) begin
        if (!reset_n) begin
            we_cnt  = 0;
            prev_we = 1'b1;
        end else begin
            if (!CS) cs_cycles++;
            if (!CS && !WE) begin
                if (prev_we) begin
                    check_eq("oe_high", 64'(OE), 64'd1);
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_write", 64'(exp_q.size()), 64'd1);
                    end else begin
                        cur_exp = exp_q.pop_front();
                    end
                    if (period_en && last_start >= 0) begin
                        check_eq("write_period", 64'(cycle - last_start), 64'(WE_PULSE + 3));
                    end
                    last_start = cycle;
                end
                check_eq("wr_addr", 64'(Address), 64'(cur_exp[63:32]));
                check_eq("wr_data", 64'(mem_data), 64'(cur_exp[31:0]));
                we_cnt++;
            end else if (we_cnt != 0) begin
                check_eq("we_pulse_len", 64'(we_cnt), 64'(WE_PULSE));
                we_cnt = 0;
            end
            prev_we = WE;
        end
    end

    // now=1 asserts reset within the current cycle instead of the next one.
    task automatic do_reset(input bit now);
        if (!now) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_cs", 64'(CS), 64'd1);
        check_eq("rst_we", 64'(WE), 64'd1);
        check_eq("rst_oe", 64'(OE), 64'd1);
        check_eq("rst_ready", 64'(in_ready), 64'd0);
        check_eq("rst_done", 64'(boot_done), 64'd0);
        check_eq("rst_error", 64'(boot_error), 64'd0);
        check_eq("rst_words", 64'(words_loaded), 64'd0);
        check_eq("rst_addr", 64'(Address), 64'd0);
        repeat (2) @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b1;
        #1 check_eq("ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1 check_eq("ready_after_edge", 64'(in_ready), 64'd1);
        exp_q.delete();
        period_en  = 1'b0;
        last_start = -1;
    endtask

    // gap=1 toggles in_valid every cycle and drives junk while invalid.
    task automatic send_word(input logic [31:0] w, input bit gap);
        bit sent = 1'b0;
        for (int n = 0; n < 100 && !sent; n++) begin
            @(negedge clock);
            in_valid = gap ? ~in_valid : 1'b1;
            in_data  = in_valid ? w : 32'hDEAD_BEEF;
            if (in_valid && in_ready) begin
                @(posedge clock);
                sent = 1'b1;
            end
        end
        if (!sent) check_eq("handshake_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic send_image(input logic [31:0] len, input logic [31:0] base,
                              input logic [31:0] sum, input bit gap);
        send_word(len, gap);
        send_word(base, gap);
        foreach (img[i]) begin
            exp_q.push_back({base + 32'(i), img[i]});
            send_word(img[i], gap);
        end
        send_word(sum, gap);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic check_end(input string tag, input bit done, input bit err,
                             input logic [31:0] words);
        check_eq({tag, "_done"}, 64'(boot_done), 64'(done));
        check_eq({tag, "_error"}, 64'(boot_error), 64'(err));
        check_eq({tag, "_words"}, 64'(words_loaded), 64'(words));
        check_eq({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_ready"}, 64'(in_ready), 64'd0);
        check_eq({tag, "_excl"}, 64'(boot_done & boot_error), 64'd0);
    endtask

    initial begin
        int c0;
        bit hit;

        do_reset(1'b0);

        // Good image, in_valid held high.
        img = '{32'hA, 32'hB, 32'hC};
        period_en = 1'b1;
        send_image(32'd3, 32'h100, 32'h21, 1'b0);
        check_end("good", 1'b1, 1'b0, 32'd3);
        check_eq("good_last_addr", 64'(Address), 64'h102);
        repeat (5) @(negedge clock);
        check_eq("good_done_held", 64'(boot_done), 64'd1);

        // Bad checksum: all writes still happen.
        do_reset(1'b0);
        img = '{32'hA, 32'hB, 32'hC};
        send_image(32'd3, 32'h100, 32'h22, 1'b0);
        check_end("badsum", 1'b0, 1'b1, 32'd3);

        // Oversized LEN: rejected immediately, no bus activity.
        do_reset(1'b0);
        c0 = cs_cycles;
        send_word(32'd1025, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        check_eq("len_error", 64'(boot_error), 64'd1);
        check_eq("len_done", 64'(boot_done), 64'd0);
        check_eq("len_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clock);
        check_eq("len_no_cs", 64'(cs_cycles - c0), 64'd0);

        // Empty image.
        do_reset(1'b0);
        img.delete();
        c0 = cs_cycles;
        send_image(32'd0, 32'd0, 32'd0, 1'b0);
        check_end("empty", 1'b1, 1'b0, 32'd0);
        check_eq("empty_no_cs", 64'(cs_cycles - c0), 64'd0);

        // Address wrap with in_valid toggling.
        do_reset(1'b0);
        img = '{32'h11, 32'h22};
        send_image(32'd2, 32'hFFFF_FFFF, 32'h33, 1'b1);
        check_end("wrap", 1'b1, 1'b0, 32'd2);
        check_eq("wrap_last_addr", 64'(Address), 64'h0);

        // Reset during the WE pulse of word 2, then a fresh image.
        do_reset(1'b0);
        send_word(32'd3, 1'b0);
        send_word(32'h200, 1'b0);
        exp_q.push_back({32'h200, 32'h1});
        send_word(32'h1, 1'b0);
        exp_q.push_back({32'h201, 32'h2});
        send_word(32'h2, 1'b0);
        hit = 1'b0;
        for (int n = 0; n < 20 && !hit; n++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (!WE) hit = 1'b1;
        end
        check_eq("midwrite_we_seen", 64'(hit), 64'd1);
        check_eq("midwrite_words", 64'(words_loaded), 64'd1);
        do_reset(1'b1);
        img = '{32'h5, 32'h6};
        send_image(32'd2, 32'h40, 32'hB, 1'b0);
        check_end("reload", 1'b1, 1'b0, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
